// File: rtl/pi_line_ctrl.sv
// Line-following steering controller: sequences IR pairs through the A2D,
// forms a weighted left/right error and runs a decimated PI loop on motor duty.
module pi_line_ctrl #(
  parameter int N_PAIRS    = 3,
  parameter int RES_W      = 12,
  parameter int OUT_W      = 11,
  parameter int SETTLE_CYC = 4096,
  parameter int GAP_CYC    = 32,
  parameter int INT_DEC    = 4,
  parameter int FWD_MAX    = 1792,
  localparam int CH_W      = (2 * N_PAIRS > 2) ? $clog2(2 * N_PAIRS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  input  logic [7:0]              kp,
  input  logic [7:0]              ki,
  input  logic                    cnv_cmplt,
  input  logic [RES_W-1:0]        res,
  output logic                    strt_cnv,
  output logic [CH_W-1:0]         chnnl,
  output logic [N_PAIRS-1:0]      ir_en,
  output logic [OUT_W-1:0]        lft,
  output logic [OUT_W-1:0]        rht,
  output logic signed [RES_W-1:0] err,
  output logic                    vld
);
  localparam int K_W   = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam int CNT_W = $clog2((SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC) + 1;
  localparam int DEC_W = (INT_DEC > 1) ? $clog2(INT_DEC) : 1;
  localparam int ACC_W = RES_W + N_PAIRS + 2;
  localparam int P_W   = RES_W + 9;
  localparam int U_W   = RES_W + 1;
  localparam int D_W   = ((OUT_W > RES_W) ? OUT_W : RES_W) + 3;

  localparam logic signed [P_W-1:0]   P_MAX = P_W'(2 ** (RES_W - 1) - 1);
  localparam logic signed [P_W-1:0]   P_MIN = P_W'(-(2 ** (RES_W - 1)));
  localparam logic signed [RES_W-1:0] S_MAX = RES_W'(2 ** (RES_W - 1) - 1);
  localparam logic signed [RES_W-1:0] S_MIN = RES_W'(-(2 ** (RES_W - 1)));
  localparam logic signed [D_W-1:0]   D_MAX = D_W'(2 ** OUT_W - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CNV_A, GAP, CNV_B, PI, OUT} state_t;
  state_t state, state_nxt;

  logic [K_W-1:0]          k;
  logic [CNT_W-1:0]        cnt;
  logic [DEC_W-1:0]        dec;
  logic [OUT_W-1:0]        fwd;
  logic signed [ACC_W-1:0] acc, res_sh;
  logic signed [RES_W-1:0] intgrl, err_new, pcomp, icomp;
  logic signed [P_W-1:0]   i_sum, p_prod, i_prod;
  logic signed [U_W-1:0]   u;
  logic signed [D_W-1:0]   l_sum, r_sum;
  logic                    last_pair, settle_done, gap_done;

  function automatic logic signed [RES_W-1:0] sat_s(input logic signed [P_W-1:0] v);
    if (v > P_MAX) return S_MAX;
    else if (v < P_MIN) return S_MIN;
    else return v[RES_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] clamp_u(input logic signed [D_W-1:0] v);
    if (v[D_W-1]) return '0;
    else if (v > D_MAX) return '1;
    else return v[OUT_W-1:0];
  endfunction

  assign last_pair   = (k == K_W'(N_PAIRS - 1));
  assign settle_done = (cnt == CNT_W'(SETTLE_CYC - 1));
  assign gap_done    = (cnt == CNT_W'(GAP_CYC - 1));
  assign res_sh      = $signed(ACC_W'(res) << k);
  assign ir_en       = (state == IDLE) ? '0 : (N_PAIRS'(1) << k);

  // Full-width signed arithmetic, saturated back to RES_W before use.
  assign err_new = sat_s(P_W'(acc));
  assign i_sum   = P_W'(intgrl) + P_W'(err_new);
  assign p_prod  = P_W'(err) * P_W'($signed({1'b0, kp}));
  assign i_prod  = P_W'(intgrl) * P_W'($signed({1'b0, ki}));
  assign pcomp   = sat_s(p_prod >>> 4);
  assign icomp   = sat_s(i_prod >>> 4);
  assign u       = U_W'(pcomp) + U_W'(icomp);
  assign l_sum   = D_W'($signed({1'b0, fwd})) + D_W'(u);
  assign r_sum   = D_W'($signed({1'b0, fwd})) - D_W'(u);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // strt_cnv is a one-cycle request; the converter answers with a one-cycle
  // cnv_cmplt carrying res. Only a response seen in CNV_A/CNV_B is consumed.
  always_comb begin
    state_nxt = state;
    if (!go) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SETTLE;
        SETTLE:  if (settle_done) state_nxt = CNV_A;
        CNV_A:   if (cnv_cmplt) state_nxt = GAP;
        GAP:     if (gap_done) state_nxt = CNV_B;
        CNV_B:   if (cnv_cmplt) state_nxt = last_pair ? PI : SETTLE;
        PI:      state_nxt = OUT;
        OUT:     state_nxt = SETTLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strt_cnv <= 1'b0;
      chnnl    <= '0;
      lft      <= '0;
      rht      <= '0;
      err      <= '0;
      vld      <= 1'b0;
      k        <= '0;
      cnt      <= '0;
      dec      <= '0;
      fwd      <= '0;
      acc      <= '0;
      intgrl   <= '0;
    end else begin
      strt_cnv <= 1'b0;
      vld      <= 1'b0;
      if (!go) begin
        lft    <= '0;
        rht    <= '0;
        err    <= '0;
        k      <= '0;
        cnt    <= '0;
        dec    <= '0;
        fwd    <= '0;
        acc    <= '0;
        intgrl <= '0;
      end else begin
        case (state)
          IDLE: begin
            k   <= '0;
            cnt <= '0;
          end
          SETTLE: begin
            if (settle_done) begin
              strt_cnv <= 1'b1;
              chnnl    <= CH_W'({k, 1'b0});
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CNV_A: if (cnv_cmplt) acc <= acc + res_sh;
          GAP: begin
            if (gap_done) begin
              strt_cnv <= 1'b1;
              chnnl    <= CH_W'({k, 1'b1});
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CNV_B: begin
            if (cnv_cmplt) begin
              acc <= acc - res_sh;
              if (!last_pair) k <= k + 1'b1;
            end
          end
          PI: begin
            err <= err_new;
            if (dec == DEC_W'(INT_DEC - 1)) begin
              intgrl <= sat_s(i_sum);
              dec    <= '0;
            end else begin
              dec <= dec + 1'b1;
            end
          end
          OUT: begin
            // lft/rht use the speed from before this period's ramp step.
            lft <= clamp_u(l_sum);
            rht <= clamp_u(r_sum);
            vld <= 1'b1;
            if (fwd < OUT_W'(FWD_MAX)) fwd <= fwd + 1'b1;
            acc <= '0;
            k   <= '0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pi_line_ctrl.sv
// Bench for pi_line_ctrl: randomized A2D responder, per-period arithmetic model,
// per-cycle output comparison and a few hand-computed scenario values.
module tb_pi_line_ctrl;
  localparam int NP = 4, RW = 12, OW = 11, SETTLE = 20, GAP = 6, INTD = 4, FMAX = 60;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n, go, cnv_cmplt, strt_cnv, vld;
  logic [7:0] kp, ki;
  logic [RW-1:0] res;
  logic [CW-1:0] chnnl;
  logic [NP-1:0] ir_en;
  logic [OW-1:0] lft, rht;
  logic signed [RW-1:0] err;

  pi_line_ctrl #(
    .N_PAIRS(NP), .RES_W(RW), .OUT_W(OW), .SETTLE_CYC(SETTLE), .GAP_CYC(GAP),
    .INT_DEC(INTD), .FWD_MAX(FMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .kp(kp), .ki(ki), .cnv_cmplt(cnv_cmplt),
    .res(res), .strt_cnv(strt_cnv), .chnnl(chnnl), .ir_en(ir_en), .lft(lft),
    .rht(rht), .err(err), .vld(vld)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int mode = 1, vld_cnt = 0, pend_cnt = 0;
  bit stray_en = 0, running = 0, pend_live = 0, ref_on = 0, ref_settle = 0;
  longint ref_edge = 0, vld_edge = -1, err_edge = -1;
  logic [CW-1:0] pend_ch;
  logic [CW-1:0] exp_q[$];
  longint a_res[NP], b_res[NP];
  longint m_fwd = 0, m_intg = 0, m_nper = 0;
  longint exp_lft = 0, exp_rht = 0, exp_err = 0, nxt_lft = 0, nxt_rht = 0, nxt_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic longint sat_r(input longint v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic longint clamp_o(input longint v);
    if (v < 0) return 0;
    if (v > 2047) return 2047;
    return v;
  endfunction

  function automatic logic [RW-1:0] res_for(input int ch);
    int p;
    bit b;
    p = ch / 2;
    b = (ch % 2) == 1;
    case (mode)
      1:       return 12'h800;
      2:       return (p == 0) ? (b ? 12'h180 : 12'h100) : 12'h800;
      3:       return (p == 2) ? (b ? 12'h000 : 12'hFFF) : 12'h800;
      4:       return (p == 0) ? (b ? 12'h800 : 12'h864) : 12'h555;
      default: return RW'($urandom_range(0, 4095));
    endcase
  endfunction

  // One control period: weighted difference, saturations, decimated integral, ramp.
  task automatic model_period();
    longint acc, e, p, i, u;
    acc = 0;
    for (int q = 0; q < NP; q++) acc += (a_res[q] - b_res[q]) * (longint'(1) << q);
    e = sat_r(acc);
    if (m_nper % INTD == INTD - 1) m_intg = sat_r(m_intg + e);
    m_nper++;
    p = sat_r((e * longint'(kp)) >>> 4);
    i = sat_r((m_intg * longint'(ki)) >>> 4);
    u = p + i;
    nxt_err = e;
    nxt_lft = clamp_o(m_fwd + u);
    nxt_rht = clamp_o(m_fwd - u);
    m_fwd = (m_fwd + 1 > FMAX) ? FMAX : m_fwd + 1;
  endtask

  task automatic fill_q();
    for (int c = 0; c < 2 * NP; c++) exp_q.push_back(CW'(c));
  endtask

  // monitor, A2D responder and scoreboard
  initial begin : monitor
    bit exp_strt, exp_v;
    int ir_pair;
    longint edge_c;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_strt = running && ref_on && (cyc == ref_edge + (ref_settle ? SETTLE : GAP));
        exp_v = running && (vld_edge == cyc);
        if (running && err_edge == cyc) exp_err = nxt_err;
        if (exp_v) begin
          exp_lft = nxt_lft;
          exp_rht = nxt_rht;
          vld_cnt++;
          vld_edge = -1;
          ref_on = 1;
          ref_settle = 1;
          ref_edge = cyc;
        end
        chk("strt_cnv", strt_cnv, exp_strt);
        chk("vld", vld, exp_v);
        chk("lft", lft, exp_lft);
        chk("rht", rht, exp_rht);
        chk("err", err, exp_err);
        ir_pair = (exp_q.size() > 0) ? int'(exp_q[0]) / 2 : 0;
        if (!running) chk("ir_en_idle", ir_en, 0);
        else if (ref_on && ref_settle && cyc < ref_edge + SETTLE)
          chk("ir_en_settle", ir_en, longint'(1) << ir_pair);

        cnv_cmplt = 1'b0;
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            res = res_for(int'(pend_ch));
            cnv_cmplt = 1'b1;
            if (pend_live && running) begin
              edge_c = cyc + 1;
              if (pend_ch % 2 == 0) begin
                a_res[pend_ch / 2] = res;
                ref_on = 1;
                ref_settle = 0;
                ref_edge = edge_c;
              end else begin
                b_res[pend_ch / 2] = res;
                if (pend_ch / 2 < NP - 1) begin
                  ref_on = 1;
                  ref_settle = 1;
                  ref_edge = edge_c;
                end else begin
                  model_period();
                  err_edge = edge_c + 1;
                  vld_edge = edge_c + 2;
                end
              end
            end
            pend_live = 0;
          end
        end else if (stray_en && !strt_cnv && $urandom_range(0, 7) == 0) begin
          res = RW'($urandom_range(0, 4095));
          cnv_cmplt = 1'b1;
        end

        if (exp_strt && strt_cnv) begin
          chk("chnnl", chnnl, exp_q[0]);
          pend_ch = exp_q.pop_front();
          if (exp_q.size() == 0) fill_q();
          pend_cnt = $urandom_range(1, 4);
          pend_live = 1;
          ref_on = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic start_go(input int md, input logic [7:0] p, input logic [7:0] i, input bit st);
    @(negedge clk);
    #1;
    mode = md;
    kp = p;
    ki = i;
    stray_en = st;
    vld_cnt = 0;
    exp_q.delete();
    fill_q();
    go = 1'b1;
    running = 1;
    ref_on = 1;
    ref_settle = 1;
    ref_edge = cyc + 1;
  endtask

  task automatic stop_go();
    #1;
    go = 1'b0;
    running = 0;
    pend_live = 0;
    ref_on = 0;
    vld_edge = -1;
    err_edge = -1;
    exp_q.delete();
    m_fwd = 0;
    m_intg = 0;
    m_nper = 0;
    exp_lft = 0;
    exp_rht = 0;
    exp_err = 0;
  endtask

  task automatic wait_vld(input int target);
    int t, budget;
    t = 0;
    budget = (target - vld_cnt + 1) * 400;
    while (vld_cnt < target && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (vld_cnt < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL vld_timeout: got %0d updates expected %0d", vld_cnt, target);
    end
  endtask

  task automatic wait_strt();
    int t;
    t = 0;
    while (!strt_cnv && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!strt_cnv) begin
      n_chk++;
      n_fail++;
      $display("FAIL strt_timeout: got 0 expected 1");
    end
  endtask

  initial begin : main
    rst_n = 1'b0;
    go = 1'b0;
    kp = 8'd16;
    ki = 8'd0;
    cnv_cmplt = 1'b0;
    res = '0;
    repeat (3) @(negedge clk);
    chk("rst_strt_cnv", strt_cnv, 0);
    chk("rst_chnnl", chnnl, 0);
    chk("rst_ir_en", ir_en, 0);
    chk("rst_lft", lft, 0);
    chk("rst_rht", rht, 0);
    chk("rst_err", err, 0);
    chk("rst_vld", vld, 0);
    chk("pin_sat_hi", sat_r(16380), 2047);
    chk("pin_sat_lo", sat_r(-5000), -2048);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // balanced inputs: duty follows the forward ramp only
    start_go(1, 8'd16, 8'd0, 0);
    wait_vld(1);
    chk("t1_lft_1", lft, 0);
    chk("t1_rht_1", rht, 0);
    wait_vld(2);
    chk("t1_lft_2", lft, 1);
    chk("t1_rht_2", rht, 1);
    stop_go();
    repeat (3) @(negedge clk);

    // inner pair imbalance of -128
    start_go(2, 8'd16, 8'd0, 1);
    wait_vld(1);
    chk("t2_err", err, -128);
    chk("t2_lft", lft, 0);
    chk("t2_rht", rht, 128);
    stop_go();
    repeat (3) @(negedge clk);

    // large imbalance on pair 2 saturates the error
    start_go(3, 8'd16, 8'd0, 1);
    wait_vld(1);
    chk("t3_err", err, 2047);
    chk("t3_lft", lft, 2047);
    chk("t3_rht", rht, 0);
    stop_go();
    repeat (3) @(negedge clk);

    // constant error with integral gain; ramp and integral both saturate
    start_go(4, 8'd16, 8'd16, 1);
    wait_vld(1);
    chk("t4_lft_1", lft, 100);
    chk("t4_rht_1", rht, 0);
    wait_vld(4);
    chk("t4_lft_4", lft, 203);
    wait_vld(90);
    chk("t4_lft_90", lft, 2047);
    chk("t4_rht_90", rht, 0);
    stop_go();
    repeat (3) @(negedge clk);

    // random run, then drop go while a conversion is in flight
    start_go(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
    wait_vld(6);
    wait_strt();
    stop_go();
    repeat (2) @(negedge clk);
    chk("t5_ir_en", ir_en, 0);
    chk("t5_lft", lft, 0);
    chk("t5_rht", rht, 0);
    repeat (6) @(negedge clk);
    start_go(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
    wait_vld(30);
    stop_go();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
